// File: rtl/cpu5_decq_dec.sv
// cpu5_decq_dec: purely combinational RV32I main decoder.
//   instr   : raw 32-bit instruction
//   ctrl    : control word (all zero for illegal encodings)
//   illegal : encoding not supported
//   funct3, rd, rs1, rs2 : raw instruction fields
// Macro CPU5_DECQ_RV32M_EN enables the M extension on OP/funct7=0000001.
`include "cpu5_defines.sv"

module cpu5_decq_dec (
  input  logic [31:0]                    instr,
  output logic [`CPU5_DEC_CTRL_SIZE-1:0] ctrl,
  output logic                           illegal,
  output logic [2:0]                     funct3,
  output logic [4:0]                     rd,
  output logic [4:0]                     rs1,
  output logic [4:0]                     rs2
);
  logic [6:0] opc, f7;
  logic       rw, rdst, asrc, br, mw, mtr, jmp, bad;
  logic [`CPU5_ALU_OP_SIZE-1:0] aop, base_op;
  logic [2:0] imm;

  assign opc    = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  // funct3 -> ALU op for OP/OP-IMM with the base funct7
  always_comb begin
    base_op = `CPU5_ALU_ADD;
    case (funct3)
      3'd1: base_op = `CPU5_ALU_SLL;
      3'd2: base_op = `CPU5_ALU_SLT;
      3'd3: base_op = `CPU5_ALU_SLTU;
      3'd4: base_op = `CPU5_ALU_XOR;
      3'd5: base_op = `CPU5_ALU_SRL;
      3'd6: base_op = `CPU5_ALU_OR;
      3'd7: base_op = `CPU5_ALU_AND;
      default: base_op = `CPU5_ALU_ADD;
    endcase
  end

  always_comb begin
    rw = 1'b0; rdst = 1'b0; asrc = 1'b0; br = 1'b0;
    mw = 1'b0; mtr = 1'b0; jmp = 1'b0; bad = 1'b0;
    aop = `CPU5_ALU_ADD;
    imm = `CPU5_IMMTYPE_R;
    if (instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opc)
        `CPU5_OPC_LUI: begin
          rw = 1'b1; rdst = 1'b1; asrc = 1'b1;
          aop = `CPU5_ALU_PASSB; imm = `CPU5_IMMTYPE_U;
        end
        `CPU5_OPC_AUIPC: begin
          rw = 1'b1; rdst = 1'b1; asrc = 1'b1;
          aop = `CPU5_ALU_ADDPC; imm = `CPU5_IMMTYPE_U;
        end
        `CPU5_OPC_JAL: begin
          rw = 1'b1; rdst = 1'b1; jmp = 1'b1; imm = `CPU5_IMMTYPE_J;
        end
        `CPU5_OPC_JALR: begin
          rw = 1'b1; rdst = 1'b1; asrc = 1'b1; jmp = 1'b1;
          imm = `CPU5_IMMTYPE_I;
        end
        `CPU5_OPC_BRANCH: begin
          br = 1'b1; aop = `CPU5_ALU_SUB; imm = `CPU5_IMMTYPE_B;
          bad = (funct3 == 3'd2) || (funct3 == 3'd3);
        end
        `CPU5_OPC_LOAD: begin
          rw = 1'b1; rdst = 1'b1; asrc = 1'b1; mtr = 1'b1;
          imm = `CPU5_IMMTYPE_I;
          bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        `CPU5_OPC_STORE: begin
          asrc = 1'b1; mw = 1'b1; imm = `CPU5_IMMTYPE_S;
          bad = (funct3 > 3'd2);
        end
        `CPU5_OPC_OPIMM: begin
          rw = 1'b1; rdst = 1'b1; asrc = 1'b1; imm = `CPU5_IMMTYPE_I;
          aop = base_op;
          // only the shift-immediates carry a funct7
          if (funct3 == 3'd1) begin
            bad = (f7 != 7'd0);
          end else if (funct3 == 3'd5) begin
            if (f7 == 7'b0100000) aop = `CPU5_ALU_SRA;
            else                  bad = (f7 != 7'd0);
          end
        end
        `CPU5_OPC_OP: begin
          rw = 1'b1; rdst = 1'b1;
          aop = base_op;
          if (f7 == 7'b0100000) begin
            if (funct3 == 3'd0)      aop = `CPU5_ALU_SUB;
            else if (funct3 == 3'd5) aop = `CPU5_ALU_SRA;
            else                     bad = 1'b1;
          end else if (f7 == 7'b0000001) begin
`ifdef CPU5_DECQ_RV32M_EN
            aop = `CPU5_ALU_MUL + {2'b00, funct3};
`else
            bad = 1'b1;
`endif
          end else if (f7 != 7'd0) begin
            bad = 1'b1;
          end
        end
        `CPU5_OPC_FENCE: ; // nop: all-zero control word, legal
        default: bad = 1'b1;
      endcase
    end
    illegal = bad;
    ctrl    = bad ? '0 : {rw, rdst, asrc, br, mw, mtr, jmp, aop, imm};
  end
endmodule

// File: rtl/cpu5_defines.sv
// cpu5 shared defines: control-word layout, ALU op codes, immediate types
// and RV32I opcodes. This is an include file (guarded), pulled in by every
// cpu5 block that needs it.
//
// Control word layout (MSB..LSB):
//   {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump,
//    aluop[4:0], immtype[2:0]}
`ifndef CPU5_DEFINES_SV
`define CPU5_DEFINES_SV

`define CPU5_DEC_CTRL_SIZE 15
`define CPU5_ALU_OP_SIZE   5

`define CPU5_ALU_ADD    5'd0
`define CPU5_ALU_SUB    5'd1
`define CPU5_ALU_SLL    5'd2
`define CPU5_ALU_SLT    5'd3
`define CPU5_ALU_SLTU   5'd4
`define CPU5_ALU_XOR    5'd5
`define CPU5_ALU_SRL    5'd6
`define CPU5_ALU_SRA    5'd7
`define CPU5_ALU_OR     5'd8
`define CPU5_ALU_AND    5'd9
`define CPU5_ALU_PASSB  5'd10
`define CPU5_ALU_ADDPC  5'd11
// M codes are contiguous in funct3 order so MUL + funct3 selects the op.
`define CPU5_ALU_MUL    5'd12
`define CPU5_ALU_MULH   5'd13
`define CPU5_ALU_MULHSU 5'd14
`define CPU5_ALU_MULHU  5'd15
`define CPU5_ALU_DIV    5'd16
`define CPU5_ALU_DIVU   5'd17
`define CPU5_ALU_REM    5'd18
`define CPU5_ALU_REMU   5'd19

`define CPU5_IMMTYPE_R  3'd0
`define CPU5_IMMTYPE_I  3'd1
`define CPU5_IMMTYPE_S  3'd2
`define CPU5_IMMTYPE_B  3'd3
`define CPU5_IMMTYPE_U  3'd4
`define CPU5_IMMTYPE_J  3'd5

`define CPU5_OPC_LUI    7'b0110111
`define CPU5_OPC_AUIPC  7'b0010111
`define CPU5_OPC_JAL    7'b1101111
`define CPU5_OPC_JALR   7'b1100111
`define CPU5_OPC_BRANCH 7'b1100011
`define CPU5_OPC_LOAD   7'b0000011
`define CPU5_OPC_STORE  7'b0100011
`define CPU5_OPC_OPIMM  7'b0010011
`define CPU5_OPC_OP     7'b0110011
`define CPU5_OPC_FENCE  7'b0001111

`endif

// File: rtl/cpu5_decq.sv
// cpu5_decq: registered, queued RV32I main decoder.
// Instructions are decoded on entry and stored in a DEPTH-entry FIFO;
// outputs come straight from the head slot (zeroed while empty).
//   clk/resetn : clock, async active-low reset
//   flush      : synchronous queue clear, wins over push/pop
//   in_*       : fetch side valid/ready, instr, pc
//   out_*      : execute side valid/ready and decoded head entry
// Macro CPU5_DECQ_RV32M_EN (in cpu5_decq_dec) enables the M extension.
`include "cpu5_defines.sv"

module cpu5_decq #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_instr,
  input  logic [PC_W-1:0]                in_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [`CPU5_DEC_CTRL_SIZE-1:0] out_ctrl,
  output logic [2:0]                     out_funct3,
  output logic [4:0]                     out_rd,
  output logic [4:0]                     out_rs1,
  output logic [4:0]                     out_rs2,
  output logic [PC_W-1:0]                out_pc,
  output logic [31:0]                    out_instr,
  output logic                           out_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [`CPU5_DEC_CTRL_SIZE-1:0] ctrl;
    logic                           illegal;
    logic [2:0]                     funct3;
    logic [4:0]                     rd;
    logic [4:0]                     rs1;
    logic [4:0]                     rs2;
    logic [PC_W-1:0]                pc;
    logic [31:0]                    instr;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          dec_ent, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          push, pop;

  cpu5_decq_dec u_dec (
    .instr   (in_instr),
    .ctrl    (dec_ent.ctrl),
    .illegal (dec_ent.illegal),
    .funct3  (dec_ent.funct3),
    .rd      (dec_ent.rd),
    .rs1     (dec_ent.rs1),
    .rs2     (dec_ent.rs2)
  );
  assign dec_ent.pc    = in_pc;
  assign dec_ent.instr = in_instr;

  // in_ready looks at occupancy only, so a full queue refuses a push even
  // when the head is being popped in the same cycle.
  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec_ent;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_ctrl    = head.ctrl;
  assign out_illegal = head.illegal;
  assign out_funct3  = head.funct3;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
endmodule

// File: tb/tb_cpu5_decq.sv
// Bench for cpu5_decq: decode vector table, directed FIFO corner cases,
// then randomized traffic checked against a queue model.
module tb_cpu5_decq;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SRA = 5'd7;
  localparam logic [4:0] A_PASSB = 5'd10, A_ADDPC = 5'd11;
  localparam logic [4:0] A_MUL = 5'd12, A_DIV = 5'd16;
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5;

  logic clk = 1'b0;
  logic resetn, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [14:0] out_ctrl;
  logic [2:0] out_funct3;
  logic [4:0] out_rd, out_rs1, out_rs2;

  always #5 clk = ~clk;

  cpu5_decq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_pc(out_pc), .out_instr(out_instr), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [14:0] ctrl;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;
  vec_t tbl[$];

  typedef struct { int idx; logic [31:0] pc; } mq_t;
  mq_t mq[$];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // flags = {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump}
  function automatic logic [14:0] mk(input logic [6:0] flags, input logic [4:0] aop,
                                     input logic [2:0] imm);
    return {flags, aop, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string nm, input int i, input logic [31:0] pc);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_ctrl"},  out_ctrl,  tbl[i].ctrl);
    chk({nm, "_ill"},   out_illegal, tbl[i].ill);
    chk({nm, "_instr"}, out_instr, tbl[i].instr);
    chk({nm, "_pc"},    out_pc,    pc);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    tbl.push_back('{32'h00500093, mk(7'b1110000, A_ADD,   T_I), 1'b0, 5'd1}); // 0 addi
    tbl.push_back('{32'h0000A103, mk(7'b1110010, A_ADD,   T_I), 1'b0, 5'd2}); // 1 lw
    tbl.push_back('{32'h002081B3, mk(7'b1100000, A_ADD,   T_R), 1'b0, 5'd3}); // 2 add
    tbl.push_back('{32'h00302223, mk(7'b0010100, A_ADD,   T_S), 1'b0, 5'd4}); // 3 sw
    tbl.push_back('{32'h000010B7, mk(7'b1110000, A_PASSB, T_U), 1'b0, 5'd1}); // lui
    tbl.push_back('{32'h00001097, mk(7'b1110000, A_ADDPC, T_U), 1'b0, 5'd1}); // auipc
    tbl.push_back('{32'h008000EF, mk(7'b1100001, A_ADD,   T_J), 1'b0, 5'd1}); // jal
    tbl.push_back('{32'h000080E7, mk(7'b1110001, A_ADD,   T_I), 1'b0, 5'd1}); // jalr
    tbl.push_back('{32'h00208463, mk(7'b0001000, A_SUB,   T_B), 1'b0, 5'd8}); // beq
    tbl.push_back('{32'h40208033, mk(7'b1100000, A_SUB,   T_R), 1'b0, 5'd0}); // sub
    tbl.push_back('{32'h4010D093, mk(7'b1110000, A_SRA,   T_I), 1'b0, 5'd1}); // srai
    tbl.push_back('{32'h0000000F, 15'd0, 1'b0, 5'd0});                        // fence
    tbl.push_back('{32'h00000000, 15'd0, 1'b1, 5'd0});                        // low bits 00
    tbl.push_back('{32'h00003003, 15'd0, 1'b1, 5'd0});                        // load f3=3
    tbl.push_back('{32'h02009093, 15'd0, 1'b1, 5'd1});                        // slli bad f7
    tbl.push_back('{32'h00000073, 15'd0, 1'b1, 5'd0});                        // system opcode
    tbl.push_back('{32'h00002063, 15'd0, 1'b1, 5'd0});                        // branch f3=2
`ifdef CPU5_DECQ_RV32M_EN
    tbl.push_back('{32'h0200C0B3, mk(7'b1100000, A_DIV, T_R), 1'b0, 5'd1});   // div
    tbl.push_back('{32'h023100B3, mk(7'b1100000, A_MUL, T_R), 1'b0, 5'd1});   // mul
`else
    tbl.push_back('{32'h0200C0B3, 15'd0, 1'b1, 5'd1});                        // div
    tbl.push_back('{32'h023100B3, 15'd0, 1'b1, 5'd1});                        // mul
`endif

    // reset state, no clock edge yet
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_ctrl",      out_ctrl,  15'd0);
    chk("rst_pc",        out_pc,    32'd0);
    chk("rst_instr",     out_instr, 32'd0);
    resetn = 1'b1;
    step();

    // decode table: push one, check head, pop it
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = 1'b1; in_instr = tbl[i].instr; in_pc = 32'h1000 + 32'(4*i);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk_entry($sformatf("tbl%0d", i), i, 32'h1000 + 32'(4*i));
      chk($sformatf("tbl%0d_rd", i), out_rd, tbl[i].rd);
      chk($sformatf("tbl%0d_f3", i), out_funct3, tbl[i].instr[14:12]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("tbl%0d_empty", i), out_valid, 1'b0);
    end

    // stream lw, add with execute stalled: fills queue
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = tbl[1+i].instr; in_pc = 32'h2000 + 32'(4*i);
      step();
    end
    chk("full_in_ready", in_ready, 1'b0);
    chk_entry("full_head", 1, 32'h2000);
    // full + in_valid + out_ready: pop only, sw is refused
    in_instr = tbl[3].instr; in_pc = 32'h2008; out_ready = 1'b1;
    step();
    chk("poponly_in_ready", in_ready, 1'b1);
    chk_entry("poponly_head", 2, 32'h2004);
    // now sw is accepted while add pops (across pointer wrap)
    step();
    in_valid = 1'b0;
    chk("pp_in_ready", in_ready, 1'b1);
    chk_entry("pp_head", 3, 32'h2008);
    step();
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 1'b0);

    // flush with a concurrent push and pop
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = tbl[i].instr; in_pc = 32'h3000 + 32'(4*i);
      step();
    end
    flush = 1'b1; in_instr = tbl[0].instr; in_pc = 32'h3008; out_ready = 1'b1;
    chk("flush_cycle_in_ready", in_ready, 1'b0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    step();
    out_ready = 1'b0;
    chk("flush_after", out_valid, 1'b0);

    // async reset mid-stream
    in_valid = 1'b1; in_instr = tbl[2].instr; in_pc = 32'h4000;
    step();
    in_valid = 1'b0;
    chk("ares_pre_valid", out_valid, 1'b1);
    #3 resetn = 1'b0;
    #1;
    chk("ares_valid",    out_valid, 1'b0);
    chk("ares_in_ready", in_ready,  1'b1);
    chk("ares_ctrl",     out_ctrl,  15'd0);
    #2 resetn = 1'b1;
    step();

    // randomized traffic against a queue model
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", out_valid, mq.size() != 0);
      chk("rnd_ready", in_ready,  mq.size() < DEPTH);
      if (mq.size() != 0) begin
        chk("rnd_ctrl",  out_ctrl,    tbl[mq[0].idx].ctrl);
        chk("rnd_ill",   out_illegal, tbl[mq[0].idx].ill);
        chk("rnd_instr", out_instr,   tbl[mq[0].idx].instr);
        chk("rnd_pc",    out_pc,      mq[0].pc);
      end else begin
        chk("rnd_zero", {out_ctrl, out_pc}, '0);
      end
      begin
        int idx;
        bit do_push, do_pop;
        idx = int'($urandom_range(0, tbl.size() - 1));
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        flush     = ($urandom_range(0, 15) == 0);
        in_instr  = tbl[idx].instr;
        in_pc     = $urandom;
        if (flush) begin
          mq.delete();
        end else begin
          do_pop  = out_ready && (mq.size() > 0);
          do_push = in_valid && (mq.size() < DEPTH);
          if (do_pop) void'(mq.pop_front());
          if (do_push) mq.push_back('{idx, in_pc});
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
